// File: rtl/loom_dpi_pkg.sv
// Shared types and header layout for the DPI-C call bridge.
// Used by dpi_call_bridge and dpi_arg_serializer.
package loom_dpi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSendHdr,
    StSendArg,
    StWaitResp,
    StReturn
  } state_e;

  localparam int unsigned SeqW = 8;

  localparam int unsigned HdrFidLsb = 16;
  localparam int unsigned HdrFidW   = 16;
  localparam int unsigned HdrSeqLsb = 8;
  localparam int unsigned HdrSeqW   = 8;
  localparam int unsigned HdrCntLsb = 0;
  localparam int unsigned HdrCntW   = 8;

  localparam logic [31:0] TimeoutErrVal = 32'h0;

  function automatic logic [31:0] make_header(input logic [HdrFidW-1:0] fid,
                                              input logic [HdrSeqW-1:0] seq,
                                              input logic [HdrCntW-1:0] cnt);
    logic [31:0] hdr;
    hdr = '0;
    hdr[HdrFidLsb +: HdrFidW] = fid;
    hdr[HdrSeqLsb +: HdrSeqW] = seq;
    hdr[HdrCntLsb +: HdrCntW] = cnt;
    return hdr;
  endfunction

endpackage

// File: rtl/dpi_arg_serializer.sv
// Holds a captured call and streams it as header + argument words on a
// valid/ready channel; outputs are registered and held while stalled.
module dpi_arg_serializer
  import loom_dpi_pkg::*;
#(
  parameter int unsigned NArgs = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [HdrFidW-1:0]    func_id,
  input  logic [SeqW-1:0]       seq,
  input  logic [3:0]            cnt,
  input  logic [32*NArgs-1:0]   args,
  input  logic                  tx_ready,
  output logic                  tx_valid,
  output logic [31:0]           tx_data,
  output logic                  tx_last,
  output logic                  hs
);

  logic [32*NArgs-1:0] args_q;
  logic [3:0]          idx_q;
  logic [3:0]          cnt_q;
  logic                tx_valid_q;
  logic                tx_last_q;
  logic [31:0]         tx_data_q;

  assign hs = tx_valid_q & tx_ready;

  // Arguments leave through the low word of a shift buffer; idx_q counts
  // how many have been presented so the final one can be flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      args_q     <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      tx_data_q  <= '0;
    end else if (load) begin
      args_q     <= args;
      idx_q      <= '0;
      cnt_q      <= cnt;
      tx_valid_q <= 1'b1;
      tx_last_q  <= (cnt == 4'd0);
      tx_data_q  <= make_header(func_id, seq, {4'h0, cnt});
    end else if (hs) begin
      if (tx_last_q) begin
        tx_valid_q <= 1'b0;
        tx_last_q  <= 1'b0;
        tx_data_q  <= '0;
      end else begin
        tx_data_q <= args_q[31:0];
        args_q    <= args_q >> 32;
        tx_last_q <= ((idx_q + 4'd1) == cnt_q);
        idx_q     <= idx_q + 4'd1;
      end
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign tx_last  = tx_last_q;

endmodule

// File: rtl/dpi_call_bridge.sv
// Freezes the design around one DPI-C call, ships it to the host and returns
// the result. Define LOOM_DPI_TIMEOUT_EN to add the response timeout.
module dpi_call_bridge
  import loom_dpi_pkg::*;
#(
  parameter int unsigned N_ARGS_MAX     = 4,
  parameter int unsigned FUNC_ID_W      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    call_valid_i,
  output logic                    call_ready_o,
  input  logic [FUNC_ID_W-1:0]    call_func_id_i,
  input  logic [3:0]              call_nargs_i,
  input  logic [32*N_ARGS_MAX-1:0] call_args_i,
  output logic                    ret_valid_o,
  output logic [31:0]             ret_data_o,
  output logic                    ret_err_o,
  output logic                    design_en_o,
  output logic                    tx_valid_o,
  input  logic                    tx_ready_i,
  output logic [31:0]             tx_data_o,
  output logic                    tx_last_o,
  input  logic                    rx_valid_i,
  output logic                    rx_ready_o,
  input  logic [31:0]             rx_data_i,
  output logic [31:0]             n_calls_o
);

  if (N_ARGS_MAX < 1 || N_ARGS_MAX > 15) begin : g_bad_nargs
    $error("N_ARGS_MAX must be in 1..15");
  end
  if (FUNC_ID_W < 1 || FUNC_ID_W > 16) begin : g_bad_fid
    $error("FUNC_ID_W must be in 1..16");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  localparam logic [3:0] NArgsMax = 4'(N_ARGS_MAX);

  state_e           state_q, state_d;
  logic             call_ready_q, call_ready_d;
  logic             design_en_q, design_en_d;
  logic             rx_ready_q, rx_ready_d;
  logic             ret_valid_q, ret_valid_d;
  logic [31:0]      ret_data_q, ret_data_d;
  logic [SeqW-1:0]  seq_q, seq_d;
  logic [31:0]      n_calls_q, n_calls_d;
  logic             load;
  logic [3:0]       nargs_eff;
  logic [HdrFidW-1:0] fid_ext;
  logic             tx_hs;
  logic             tx_last;

`ifdef LOOM_DPI_TIMEOUT_EN
  logic             ret_err_q, ret_err_d;
  logic [31:0]      tmo_q, tmo_d;
`endif

  assign nargs_eff = (call_nargs_i > NArgsMax) ? NArgsMax : call_nargs_i;

  always_comb begin
    fid_ext = '0;
    fid_ext[FUNC_ID_W-1:0] = call_func_id_i;
  end

  dpi_arg_serializer #(
    .NArgs (N_ARGS_MAX)
  ) u_ser (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (load),
    .func_id  (fid_ext),
    .seq      (seq_q),
    .cnt      (nargs_eff),
    .args     (call_args_i),
    .tx_ready (tx_ready_i),
    .tx_valid (tx_valid_o),
    .tx_data  (tx_data_o),
    .tx_last  (tx_last),
    .hs       (tx_hs)
  );

  assign tx_last_o = tx_last;

  always_comb begin
    state_d    = state_q;
    ret_data_d = ret_data_q;
    seq_d      = seq_q;
    n_calls_d  = n_calls_q;
    load       = 1'b0;
`ifdef LOOM_DPI_TIMEOUT_EN
    ret_err_d  = ret_err_q;
    tmo_d      = (state_q == StWaitResp) ? tmo_q + 32'd1 : '0;
`endif

    unique case (state_q)
      StIdle: begin
        if (call_valid_i && call_ready_q) begin
          load    = 1'b1;
          state_d = StSendHdr;
`ifdef LOOM_DPI_TIMEOUT_EN
          ret_err_d = 1'b0;
`endif
        end
      end
      StSendHdr: begin
        if (tx_hs) state_d = tx_last ? StWaitResp : StSendArg;
      end
      StSendArg: begin
        if (tx_hs && tx_last) state_d = StWaitResp;
      end
      StWaitResp: begin
        // A response in the expiry cycle takes priority over the timeout.
        if (rx_valid_i && rx_ready_q) begin
          ret_data_d = rx_data_i;
          state_d    = StReturn;
`ifdef LOOM_DPI_TIMEOUT_EN
          ret_err_d  = 1'b0;
        end else if (tmo_q == TIMEOUT_CYCLES - 1) begin
          ret_data_d = TimeoutErrVal;
          ret_err_d  = 1'b1;
          state_d    = StReturn;
`endif
        end
      end
      StReturn: begin
        state_d   = StIdle;
        seq_d     = seq_q + 8'd1;
        n_calls_d = n_calls_q + 32'd1;
      end
      default: state_d = StIdle;
    endcase

    call_ready_d = (state_d == StIdle);
    design_en_d  = (state_d == StIdle);
    rx_ready_d   = (state_d == StWaitResp);
    ret_valid_d  = (state_d == StReturn);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      call_ready_q <= 1'b1;
      design_en_q  <= 1'b1;
      rx_ready_q   <= 1'b0;
      ret_valid_q  <= 1'b0;
      ret_data_q   <= '0;
      seq_q        <= '0;
      n_calls_q    <= '0;
    end else begin
      state_q      <= state_d;
      call_ready_q <= call_ready_d;
      design_en_q  <= design_en_d;
      rx_ready_q   <= rx_ready_d;
      ret_valid_q  <= ret_valid_d;
      ret_data_q   <= ret_data_d;
      seq_q        <= seq_d;
      n_calls_q    <= n_calls_d;
    end
  end

`ifdef LOOM_DPI_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ret_err_q <= 1'b0;
      tmo_q     <= '0;
    end else begin
      ret_err_q <= ret_err_d;
      tmo_q     <= tmo_d;
    end
  end
  assign ret_err_o = ret_err_q;
`else
  assign ret_err_o = 1'b0;
`endif

  assign call_ready_o = call_ready_q;
  assign design_en_o  = design_en_q;
  assign rx_ready_o   = rx_ready_q;
  assign ret_valid_o  = ret_valid_q;
  assign ret_data_o   = ret_data_q;
  assign n_calls_o    = n_calls_q;

endmodule

// File: tb/tb_dpi_call_bridge.sv
// Directed bench for dpi_call_bridge (N_ARGS_MAX=4, TIMEOUT_CYCLES=16);
// timeout steps only run when LOOM_DPI_TIMEOUT_EN is defined.
module tb_dpi_call_bridge;

  logic         clk;
  logic         rst;
  logic         call_valid;
  logic         call_ready;
  logic [7:0]   call_func_id;
  logic [3:0]   call_nargs;
  logic [127:0] call_args;
  logic         ret_valid;
  logic [31:0]  ret_data;
  logic         ret_err;
  logic         design_en;
  logic         tx_valid;
  logic         tx_ready;
  logic [31:0]  tx_data;
  logic         tx_last;
  logic         rx_valid;
  logic         rx_ready;
  logic [31:0]  rx_data;
  logic [31:0]  n_calls;

  int n_cmp  = 0;
  int n_fail = 0;

  // Per-call observations
  logic [32:0]  words[$];
  int           ret_pulses;
  int           den_low;
  bit           got_ret;
  logic [31:0]  ret_seen;
  logic         err_seen;

  dpi_call_bridge #(
    .N_ARGS_MAX     (4),
    .FUNC_ID_W      (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .call_valid_i   (call_valid),
    .call_ready_o   (call_ready),
    .call_func_id_i (call_func_id),
    .call_nargs_i   (call_nargs),
    .call_args_i    (call_args),
    .ret_valid_o    (ret_valid),
    .ret_data_o     (ret_data),
    .ret_err_o      (ret_err),
    .design_en_o    (design_en),
    .tx_valid_o     (tx_valid),
    .tx_ready_i     (tx_ready),
    .tx_data_o      (tx_data),
    .tx_last_o      (tx_last),
    .rx_valid_i     (rx_valid),
    .rx_ready_o     (rx_ready),
    .rx_data_i      (rx_data),
    .n_calls_o      (n_calls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_call_ready"}, call_ready, 1);
    chk({tag, "_design_en"}, design_en, 1);
    chk({tag, "_tx"}, {tx_valid, tx_last, tx_data}, 0);
    chk({tag, "_rx_ready"}, rx_ready, 0);
    chk({tag, "_ret"}, {ret_valid, ret_err, ret_data}, 0);
    chk({tag, "_n_calls"}, n_calls, 0);
  endtask

  // Issue one call at a negedge and follow it until the bridge is idle again.
  // delay = WaitResp cycles before rx_valid; rdy_pat[i%4] = tx_ready on the
  // i-th cycle with tx_valid; spur pulses rx_valid while arguments are sent.
  task automatic do_call(input logic [7:0] fid, input logic [3:0] nargs,
                         input logic [127:0] args, input logic [31:0] resp,
                         input int delay, input logic [3:0] rdy_pat, input bit spur);
    int  cyc, txi, waited, k;
    bit  p_valid, p_ready, p_last, in_args;
    logic [31:0] p_data;
    words.delete();
    ret_pulses = 0; den_low = 0; got_ret = 0; ret_seen = '0; err_seen = 1'b0;
    k = 0;
    while (!call_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    call_valid = 1'b1; call_func_id = fid; call_nargs = nargs; call_args = args;
    @(negedge clk);
    call_valid = 1'b0;
    chk("cycle1_frozen", {design_en, call_ready, tx_valid}, 3'b001);
    cyc = 0; txi = 0; waited = 0;
    p_valid = 0; p_ready = 0; p_last = 0; p_data = '0;
    while (!(got_ret && call_ready) && cyc < 300) begin
      if (!design_en) den_low++;
      if (ret_valid) begin
        ret_pulses++; got_ret = 1; ret_seen = ret_data; err_seen = ret_err;
      end
      if (p_valid && !p_ready)
        chk("tx_hold", {tx_valid, tx_last, tx_data}, {1'b1, p_last, p_data});
      in_args = tx_valid && (words.size() > 0);
      tx_ready = rdy_pat[2'(txi)];
      if (tx_valid) begin
        if (tx_ready) words.push_back({tx_last, tx_data});
        txi++;
      end
      rx_valid = 1'b0; rx_data = '0;
      if (rx_ready) begin
        if (waited == delay) begin
          rx_valid = 1'b1; rx_data = resp;
        end
        waited++;
      end else if (in_args) begin
        chk("rx_blocked", rx_ready, 0);
        if (spur) begin
          rx_valid = 1'b1; rx_data = 32'hBAD0_BAD0;
        end
      end
      p_valid = tx_valid; p_ready = tx_ready; p_last = tx_last; p_data = tx_data;
      @(negedge clk);
      cyc++;
    end
    rx_valid = 1'b0; tx_ready = 1'b0;
    chk("call_done", got_ret, 1);
  endtask

  initial begin
    rst = 1'b1; call_valid = 1'b0; call_func_id = '0; call_nargs = '0; call_args = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    rst = 1'b0;
    @(negedge clk);

    // ID 3, two args, response after 2 WaitResp cycles
    do_call(8'd3, 4'd2, {64'h0, 32'h0000_5670, 32'h0000_ACE1}, 32'h0000_0351, 2, 4'b1111, 0);
    chk("t1_nwords", words.size(), 3);
    chk("t1_w0", words[0], {1'b0, 32'h0003_0002});
    chk("t1_w1", words[1], {1'b0, 32'h0000_ACE1});
    chk("t1_w2", words[2], {1'b1, 32'h0000_5670});
    chk("t1_ret", {ret_pulses, ret_seen}, {32'd1, 32'h0000_0351});
    chk("t1_den_low", den_low, 7);
    chk("t1_n_calls", n_calls, 1);
    chk("t1_ret_hold", {ret_valid, ret_data}, {1'b0, 32'h0000_0351});

    // Zero args: header only, response one cycle after rx_ready
    do_call(8'h7F, 4'd0, 128'h0, 32'hDEAD_BEEF, 1, 4'b1111, 0);
    chk("t2_nwords", words.size(), 1);
    chk("t2_hdr", words[0], {1'b1, 32'h007F_0100});
    chk("t2_den_low", den_low, 4);
    chk("t2_ret", {ret_pulses, ret_seen}, {32'd1, 32'hDEAD_BEEF});
    chk("t2_n_calls", n_calls, 2);

    // Stalling tx_ready 1-0-0-1, nargs 6 clipped to 4, spurious rx in SendArg
    do_call(8'hA5, 4'd6, {32'h44, 32'h33, 32'h22, 32'h11}, 32'h1234_5678, 0, 4'b1001, 1);
    chk("t3_nwords", words.size(), 5);
    chk("t3_hdr", words[0], {1'b0, 32'h00A5_0204});
    chk("t3_a0", words[1], {1'b0, 32'h11});
    chk("t3_a1", words[2], {1'b0, 32'h22});
    chk("t3_a2", words[3], {1'b0, 32'h33});
    chk("t3_a3", words[4], {1'b1, 32'h44});
    chk("t3_den_low", den_low, 11);
    chk("t3_ret", {ret_pulses, ret_seen, 31'd0, err_seen}, {32'd1, 32'h1234_5678, 32'd0});
    chk("t3_n_calls", n_calls, 3);

`ifdef LOOM_DPI_TIMEOUT_EN
    // No response: expiry after 16 WaitResp cycles
    do_call(8'h01, 4'd0, 128'h0, 32'h0, 1000, 4'b1111, 0);
    chk("to_hdr", words[0], {1'b1, 32'h0001_0300});
    chk("to_ret", {ret_pulses, ret_seen, 31'd0, err_seen}, {32'd1, 32'h0, 32'd1});
    chk("to_den_low", den_low, 18);
    chk("to_err_held", ret_err, 1);
    chk("to_n_calls", n_calls, 4);
    // Response in the exact expiry cycle wins
    do_call(8'h02, 4'd0, 128'h0, 32'h0BAD_F00D, 15, 4'b1111, 0);
    chk("exp_hdr", words[0], {1'b1, 32'h0002_0400});
    chk("exp_ret", {ret_pulses, ret_seen, 31'd0, err_seen}, {32'd1, 32'h0BAD_F00D, 32'd0});
    chk("exp_den_low", den_low, 18);
    chk("exp_n_calls", n_calls, 5);
`endif

    // Reset pulsed during SendArg acts without a clock edge
    call_valid = 1'b1; call_func_id = 8'h09; call_nargs = 4'd3;
    call_args = {32'h0, 32'hC3, 32'hB2, 32'hA1};
    tx_ready = 1'b1;
    @(negedge clk);
    call_valid = 1'b0;
    @(negedge clk);
    tx_ready = 1'b0;
    chk("pre_rst_arg0", {tx_valid, design_en, tx_data}, {1'b1, 1'b0, 32'hA1});
    #2 rst = 1'b1;
    #1 chk_reset_vals("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 256 back-to-back calls from sequence 0, then the wrapped 257th
    for (int i = 0; i < 256; i++) begin
      logic [7:0] ib;
      ib = 8'(i);
      do_call(ib, 4'd1, {96'h0, 32'(i * 7)}, 32'(i) + 32'h100, 0, 4'b1111, 1);
      chk("loop_hdr", words[0], {1'b0, 8'h00, ib, ib, 8'h01});
      chk("loop_ret", ret_seen, 32'(i) + 32'h100);
    end
    chk("loop_n_calls", n_calls, 256);
    do_call(8'hEE, 4'd0, 128'h0, 32'h5555_AAAA, 0, 4'b1111, 0);
    chk("wrap_hdr", words[0], {1'b1, 32'h00EE_0000});
    chk("wrap_n_calls", n_calls, 257);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dpi_call_bridge.md
# dpi_call_bridge

Hardware-side bridge for one DPI-C call site in a Loom-transformed design. It accepts a call request (function ID plus up to `N_ARGS_MAX` 32-bit arguments) from the design's clocked DPI call site and freezes the design via `design_en_o`. It serialises the request as a word stream toward the host transport and waits for the one-word result. It then hands the result back and unfreezes the design. It sits directly downstream of the instrumented test logic (for example, the `dpi_add` call site) and upstream of the host channel mux.

## Interface
- `N_ARGS_MAX`, default 4, maximum arguments per call (1..15).
- `FUNC_ID_W`, default 8, width of the function ID (1..16).
- `TIMEOUT_CYCLES`, default 1024, response timeout in cycles (used only with the timeout feature).
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `call_valid_i` in 1: call request valid.
- `call_ready_o` out 1: bridge idle and able to accept a call.
- `call_func_id_i` in FUNC_ID_W: function ID.
- `call_nargs_i` in 4: argument count.
- `call_args_i` in 32*N_ARGS_MAX: arguments; arg k occupies bits [32k+31:32k].
- `ret_valid_o` out 1: one-cycle pulse with the result.
- `ret_data_o` out 32: result value.
- `ret_err_o` out 1: the result is a timeout error.
- `design_en_o` out 1: design clock-enable; low while a call is outstanding.
- `tx_valid_o` out 1, `tx_ready_i` in 1, `tx_data_o` out 32, `tx_last_o` out 1: outbound stream toward the host.
- `rx_valid_i` in 1, `rx_ready_o` out 1, `rx_data_i` in 32: inbound response word.
- `n_calls_o` out 32: count of completed calls.

## Operation
- States: Idle, SendHdr, SendArg, WaitResp, Return.
- All outputs and state are registered.
- Reset values:
  - state Idle
  - `call_ready_o`=1
  - `design_en_o`=1
  - `tx_valid_o`=0, `tx_last_o`=0, `tx_data_o`=0
  - `rx_ready_o`=0
  - `ret_valid_o`=0, `ret_err_o`=0, `ret_data_o`=0
  - `n_calls_o`=0
  - sequence counter 0
- Idle: on `call_valid_i` & `call_ready_o`, capture the function ID, the effective argument count and the arguments. Drop `design_en_o` and `call_ready_o`, then go to SendHdr.
- Effective count: `min(call_nargs_i, N_ARGS_MAX)`. Excess arguments are silently dropped.
- Header word: [31:16] function ID zero-extended, [15:8] 8-bit sequence number, [7:0] effective count.
  - `tx_last_o`=1 on the header when the count is 0.
- SendHdr and SendArg:
  - Words are presented in order: header, arg0, arg1, and so on.
  - A word advances only on `tx_valid_o` & `tx_ready_i`.
  - `tx_data_o`, `tx_last_o` and `tx_valid_o` stay stable while `tx_ready_i` is low.
  - `tx_last_o` is high on the final word.
  - After the final handshake the block goes to WaitResp.
- WaitResp: `rx_ready_o`=1. On `rx_valid_i`, latch `rx_data_i` into `ret_data_o` and go to Return.
  - `rx_valid_i` in any other state is not consumed.
- Return:
  - `ret_valid_o`=1 for exactly one cycle.
  - Sequence counter increments; 8-bit, wraps 255→0.
  - `n_calls_o` increments; wraps 2^32-1→0.
  - Next cycle: Idle with `design_en_o`=1 and `call_ready_o`=1.
- `ret_data_o` holds its value until the next Return.
- Reset asserted mid-call aborts immediately to the reset values. A partially sent stream is abandoned; the host side is responsible for resync on the sequence number.

## Timing
- Call accepted at edge 0:
  - `design_en_o` and `call_ready_o` are low from cycle 1.
  - Header is valid in cycle 1.
- With `tx_ready_i` held high and n args:
  - Header in cycle 1, args in cycles 2..n+1.
  - WaitResp from cycle n+2.
- Response handshake in cycle r: `ret_valid_o` in cycle r+1; `design_en_o`=1 and `call_ready_o`=1 in cycle r+2.
- Minimum call-to-call spacing: n+4 cycles.

## Configuration
- `LOOM_DPI_TIMEOUT_EN` defined:
  - A counter runs in WaitResp.
  - If no rx handshake occurs within `TIMEOUT_CYCLES` cycles of entering WaitResp, the block goes to Return with `ret_err_o`=1 and `ret_data_o`=0.
  - A response arriving in the expiry cycle wins: normal return, `ret_err_o`=0.
  - `ret_err_o` clears on the next accepted call.
  - Timed-out calls still increment `n_calls_o` and the sequence counter.
- `LOOM_DPI_TIMEOUT_EN` undefined: WaitResp waits forever, there is no counter logic, and `ret_err_o` is tied 0.

## Structure
- Package `loom_dpi_pkg` holds:
  - the state enum
  - the header field offsets and widths
  - the sequence number width (8)
  - the timeout error value (32'h0)
- Sub-module `dpi_arg_serializer` holds the argument buffer, the word index and the tx valid/ready/last logic. The parent owns the FSM, the response path and the counters.

## Test plan
- ID 3, nargs 2, args 0xACE1/0x5670, tx_ready always 1, response 0x0000_0351 after 2 cycles. Required: header 0x0003_0002 then 0xACE1 then 0x5670 with `tx_last_o` on the last word; `ret_data_o`=0x351 with a one-cycle `ret_valid_o`; `n_calls_o`=1.
- nargs 0. Required: a single header word with `tx_last_o`=1; full call completes with `design_en_o` low for exactly 4 cycles.
- `tx_ready_i` toggling 1-0-0-1. Required: tx words held stable while stalled and no word duplicated or lost; nargs 6 with `N_ARGS_MAX`=4 sends a header count of 4 and only 4 args.
- 256 back-to-back calls. Required: header sequence byte wraps 0xFF→0x00; `n_calls_o`=256; `rx_valid_i` pulsed during SendArg is ignored.
- `LOOM_DPI_TIMEOUT_EN` with `TIMEOUT_CYCLES`=16 and no response. Required: `ret_err_o`=1, `ret_data_o`=0 at expiry; a response in the exact expiry cycle returns normally with `ret_err_o`=0.
- `rst_i` pulsed during SendArg. Required: all outputs at reset values asynchronously; the next call starts with sequence number 0.
